// File: rtl/div_unit_if.sv
// Handshake and result bundle between the control unit and the multicycle divider.
// The control unit drives the request side; the divider returns status pulses and results.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div0, lo, hi
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div0, lo, hi
  );
endinterface

// File: rtl/div_unit.sv
// Signed restoring divider: one quotient bit per clock on operand magnitudes, then a
// sign-fix cycle that writes LOdiv/HIdiv. A zero divisor is reported on div0 instead.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE,
    S_ZERO
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CW-1:0]    r_cnt;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_busy;
  logic             r_done;
  logic             r_div0;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;

  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dsr_abs;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_quo_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_sub;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_lo_fix;
  logic [WIDTH-1:0] w_hi_fix;

  // Magnitudes are taken as unsigned, so the most negative value maps to 2^(WIDTH-1).
  assign w_dvd_abs = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign w_dsr_abs = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

  // The shifted remainder needs one extra bit; the difference always fits in WIDTH bits.
  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_quo_sh  = {r_quo[WIDTH-2:0], 1'b0};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dsr});
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_dsr;
  assign w_rem_nxt = w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
  assign w_quo_nxt = {w_quo_sh[WIDTH-1:1], w_ge};

  assign w_lo_fix  = r_qneg ? -r_quo : r_quo;
  assign w_hi_fix  = r_rneg ? -r_rem : r_rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dsr   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_div0  <= 1'b0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      r_done <= 1'b0;
      r_div0 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              r_state <= S_ZERO;
              r_div0  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_dsr   <= w_dsr_abs;
              r_quo   <= w_dvd_abs;
              r_rem   <= '0;
              r_cnt   <= CW'(WIDTH);
              r_qneg  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
              r_rneg  <= bus.dividend[WIDTH-1];
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_lo    <= w_lo_fix;
          r_hi    <= w_hi_fix;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_ZERO: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.div0 = r_div0;
  assign bus.lo   = r_lo;
  assign bus.hi   = r_hi;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results are queued at start and popped
// when done/div0 arrives; latency, busy duration and pulse counts are checked per test.
module tb_div_unit;

  localparam int W = 32;

  logic clk;
  logic reset;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    bit           zero;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] model_lo;
  logic [W-1:0] model_hi;
  int           tests_run;
  int           tests_failed;

  // Reference: 64-bit signed arithmetic truncates toward zero and has no overflow here.
  task automatic push_expected(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint la, lb, lq, lr;
    if (b == '0) begin
      e.lo = model_lo; e.hi = model_hi; e.zero = 1'b1;
    end else begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
      lq = la / lb;
      lr = la % lb;
      e.lo = lq[W-1:0]; e.hi = lr[W-1:0]; e.zero = 1'b0;
      model_lo = e.lo; model_hi = e.hi;
    end
    sb.push_back(e);
  endtask

  // Drives a one-cycle start; operands are scrambled right after the sampling edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    push_expected(a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.dividend = $urandom; bus.divisor = $urandom;
  endtask

  // Waits (bounded) for done or div0; cycles counts negedges after the start edge.
  task automatic wait_result(output int cycles, output int busy_cycles,
                             output bit got_done, output bit got_div0);
    cycles = 0; busy_cycles = 0; got_done = 0; got_div0 = 0;
    while (cycles < 100 && !got_done && !got_div0) begin
      @(negedge clk);
      cycles++;
      if (bus.busy) busy_cycles++;
      got_done = bus.done;
      got_div0 = bus.div0;
    end
  endtask

  task automatic run_and_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc, bcyc; bit gd, gz; exp_t e; bit exp_zero;
    launch(a, b);
    wait_result(cyc, bcyc, gd, gz);
    e = sb.pop_front();
    exp_zero = e.zero;
    $display("[TB] %s: %h / %h -> lo=%h hi=%h done=%0d div0=%0d cyc=%0d",
             name, a, b, bus.lo, bus.hi, gd, gz, cyc);
    tests_run++;
    if ({gd, gz} !== {!exp_zero, exp_zero}) begin
      tests_failed++;
      $display("FAIL %s pulse: done/div0=%b%b expected %b%b", name, gd, gz, !exp_zero, exp_zero);
    end
    tests_run++;
    if (cyc !== (exp_zero ? 1 : 34)) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_zero ? 1 : 34);
    end
    tests_run++;
    if (bcyc !== (exp_zero ? 0 : 33)) begin
      tests_failed++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, bcyc, exp_zero ? 0 : 33);
    end
    tests_run++;
    if ({bus.lo, bus.hi} !== {e.lo, e.hi}) begin
      tests_failed++;
      $display("FAIL %s result: lo=%h hi=%h expected lo=%h hi=%h", name, bus.lo, bus.hi, e.lo, e.hi);
    end
    @(negedge clk);
    tests_run++;
    if ({bus.done, bus.div0, bus.busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL %s pulse_width: done/div0/busy=%b expected 000", name, {bus.done, bus.div0, bus.busy});
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    model_lo = '0; model_hi = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.done, bus.div0, bus.lo, bus.hi} !== {3'b000, 64'h0}) begin
      tests_failed++;
      $display("FAIL reset_state: busy/done/div0=%b lo=%h hi=%h expected all zero",
               {bus.busy, bus.done, bus.div0}, bus.lo, bus.hi);
    end
    reset = 1'b0;
    @(negedge clk);
    $display("[TB] reset released");
  endtask

  task automatic test_positive;
    run_and_check("pos_7_2", 32'd7, 32'd2);
  endtask

  task automatic test_signed;
    run_and_check("neg_7_2", -32'sd7, 32'd2);
    run_and_check("7_neg_2", 32'd7, -32'sd2);
    run_and_check("neg_7_neg_2", -32'sd7, -32'sd2);
  endtask

  task automatic test_zero;
    run_and_check("pos_7_2_again", 32'd7, 32'd2);
    run_and_check("zero_div", 32'd5, 32'd0);
  endtask

  task automatic test_extreme;
    run_and_check("min_by_neg1", 32'h8000_0000, 32'hFFFF_FFFF);
    run_and_check("neg1_by_min", 32'hFFFF_FFFF, 32'h8000_0000);
    run_and_check("max_by_1", 32'h7FFF_FFFF, 32'd1);
    run_and_check("small_by_big", 32'd3, 32'h7FFF_FFFF);
  endtask

  task automatic test_start_while_busy;
    int cyc, n_done; exp_t e; logic [W-1:0] rlo, rhi;
    push_expected(32'd7, 32'd2);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd7; bus.divisor = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0; n_done = 0; rlo = 'x; rhi = 'x;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        n_done++;
        tests_run++;
        if (cyc !== 34) begin
          tests_failed++;
          $display("FAIL busy_restart latency: got %0d expected 34", cyc);
        end
        rlo = bus.lo; rhi = bus.hi;
      end
      if (cyc == 9) begin
        bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd10;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.divisor = 32'd0;
      end
    end
    e = sb.pop_front();
    $display("[TB] start_while_busy: dones=%0d lo=%h hi=%h", n_done, rlo, rhi);
    tests_run++;
    if (n_done !== 1) begin
      tests_failed++;
      $display("FAIL busy_restart done_count: got %0d expected 1", n_done);
    end
    tests_run++;
    if ({rlo, rhi} !== {e.lo, e.hi}) begin
      tests_failed++;
      $display("FAIL busy_restart result: lo=%h hi=%h expected lo=%h hi=%h", rlo, rhi, e.lo, e.hi);
    end
  endtask

  task automatic test_reset_mid;
    int n_done;
    launch(32'd7, 32'd2);
    repeat (15) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    sb.delete();
    model_lo = '0; model_hi = '0;
    $display("[TB] reset_mid: busy=%b lo=%h hi=%h", bus.busy, bus.lo, bus.hi);
    tests_run++;
    if ({bus.busy, bus.lo, bus.hi} !== {1'b0, 64'h0}) begin
      tests_failed++;
      $display("FAIL reset_mid clear: busy=%b lo=%h hi=%h expected 0/0/0", bus.busy, bus.lo, bus.hi);
    end
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) n_done++;
    end
    tests_run++;
    if (n_done !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid no_done: got %0d active cycles expected 0", n_done);
    end
    run_and_check("after_reset_100_10", 32'd100, 32'd10);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i == 3) ? 32'd0 : ($urandom >> (i * 5));
      run_and_check("random", a, b);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset;
    test_positive;
    test_signed;
    test_zero;
    test_extreme;
    test_start_while_busy;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
